// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Purpose: accepts ALU operations from two requesters, arbitrates between them
// round-robin, optionally fetches operand B from memory, issues the operation
// to the ALU, waits for the result and returns it to the requester that owns
// it. Only one operation is in flight at a time.
//
// Optional feature: define ALU_ISSUE_TIMEOUT_EN to bound the wait for the ALU
// result to TIMEOUT cycles. On expiry the result is returned with RES_ERR=1 and
// RES_DATA=0. Without the macro the controller waits for EX_VLD forever and no
// timer is built.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   REQ_VLD / REQ_RDY   per-requester handshake (REQ_RDY one-hot or zero)
//   REQ_OP, REQ_MOVI    per-requester opcode (4b) and operand-B source (2b)
//   REQ_A/B/IMM         per-requester operands
//   MEM_REQ/VLD/DATA    memory operand fetch
//   ALU_VLD/RDY         ALU issue handshake
//   ALU_OP/MOVI/A/B/MEM/IMM  issued operation fields, stable while ALU_VLD
//   EX_VLD, EX_DATA     ALU result
//   RES_VLD/DATA/ERR    one-hot result strobe, result and error flag
//
// State table:
//   state       | meaning
//   ------------+------------------------------------------------------------
//   S_IDLE      | arbitrate requests, latch the winner's fields on REQ_RDY
//   S_MEM_FETCH | MEM_REQ held high until MEM_VLD delivers operand B
//   S_ISSUE     | ALU_VLD held high with stable fields until ALU_RDY
//   S_WAIT_RES  | waiting for EX_VLD (or timeout when enabled)
//   S_RESP      | one-cycle RES_VLD pulse to the owning requester
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [1:0]              REQ_VLD,
    output logic [1:0]              REQ_RDY,
    input  logic [7:0]              REQ_OP,
    input  logic [3:0]              REQ_MOVI,
    input  logic [2*DATA_WIDTH-1:0] REQ_A,
    input  logic [2*DATA_WIDTH-1:0] REQ_B,
    input  logic [2*DATA_WIDTH-1:0] REQ_IMM,
    output logic                    MEM_REQ,
    input  logic                    MEM_VLD,
    input  logic [DATA_WIDTH-1:0]   MEM_DATA,
    output logic                    ALU_VLD,
    input  logic                    ALU_RDY,
    output logic [3:0]              ALU_OP,
    output logic [1:0]              ALU_MOVI,
    output logic [DATA_WIDTH-1:0]   ALU_A,
    output logic [DATA_WIDTH-1:0]   ALU_B,
    output logic [DATA_WIDTH-1:0]   ALU_MEM,
    output logic [DATA_WIDTH-1:0]   ALU_IMM,
    input  logic                    EX_VLD,
    input  logic [DATA_WIDTH-1:0]   EX_DATA,
    output logic [1:0]              RES_VLD,
    output logic [DATA_WIDTH-1:0]   RES_DATA,
    output logic                    RES_ERR
);

    localparam logic [1:0] MOVI_MEM = 2'b01;
    localparam logic [1:0] MOVI_RSV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_FETCH,
        S_ISSUE,
        S_WAIT_RES,
        S_RESP
    } state_t;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("alu_issue_ctrl: TIMEOUT must be at least 1");
    end

    state_t state;
    logic   last_gnt;   // index of the requester granted most recently
    logic   owner;      // index of the requester owning the in-flight op

    logic [1:0]            gnt;
    logic                  gnt_idx;
    logic [3:0]            sel_op;
    logic [1:0]            sel_movi;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [DATA_WIDTH-1:0] sel_imm;

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
    logic [TMR_W-1:0] tmr;
`endif

    // REQ_RDY is the combinational ready half of the request handshake: the
    // winner sees it in the same IDLE cycle its fields are captured. With
    // both requesting, the one not granted last wins.
    always_comb begin
        gnt = 2'b00;
        if (state == S_IDLE && !RST) begin
            case (REQ_VLD)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign REQ_RDY = gnt;
    assign gnt_idx = gnt[1];

    always_comb begin
        sel_op   = gnt_idx ? REQ_OP[7:4]   : REQ_OP[3:0];
        sel_movi = gnt_idx ? REQ_MOVI[3:2] : REQ_MOVI[1:0];
        sel_a    = gnt_idx ? REQ_A[2*DATA_WIDTH-1:DATA_WIDTH]
                           : REQ_A[DATA_WIDTH-1:0];
        sel_b    = gnt_idx ? REQ_B[2*DATA_WIDTH-1:DATA_WIDTH]
                           : REQ_B[DATA_WIDTH-1:0];
        sel_imm  = gnt_idx ? REQ_IMM[2*DATA_WIDTH-1:DATA_WIDTH]
                           : REQ_IMM[DATA_WIDTH-1:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            last_gnt <= 1'b1;   // requester 0 wins the first tie
            owner    <= 1'b0;
            MEM_REQ  <= 1'b0;
            ALU_VLD  <= 1'b0;
            ALU_OP   <= '0;
            ALU_MOVI <= '0;
            ALU_A    <= '0;
            ALU_B    <= '0;
            ALU_MEM  <= '0;
            ALU_IMM  <= '0;
            RES_VLD  <= '0;
            RES_DATA <= '0;
            RES_ERR  <= 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
            tmr      <= '0;
`endif
        end else begin
            RES_VLD <= '0;
            case (state)
                S_IDLE: begin
                    if (gnt != 2'b00) begin
                        owner    <= gnt_idx;
                        last_gnt <= gnt_idx;
                        ALU_OP   <= sel_op;
                        ALU_MOVI <= sel_movi;
                        ALU_A    <= sel_a;
                        ALU_B    <= sel_b;
                        ALU_IMM  <= sel_imm;
                        ALU_MEM  <= '0;
                        if (sel_movi == MOVI_MEM) begin
                            MEM_REQ <= 1'b1;
                            state   <= S_MEM_FETCH;
                        end else if (sel_movi == MOVI_RSV) begin
                            // Reserved source: answer with an error, never
                            // touch memory or the ALU.
                            RES_VLD  <= gnt;
                            RES_DATA <= '0;
                            RES_ERR  <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            ALU_VLD <= 1'b1;
                            state   <= S_ISSUE;
                        end
                    end
                end

                S_MEM_FETCH: begin
                    if (MEM_VLD) begin
                        ALU_MEM <= MEM_DATA;
                        MEM_REQ <= 1'b0;
                        ALU_VLD <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (ALU_RDY) begin
                        ALU_VLD <= 1'b0;
                        state   <= S_WAIT_RES;
`ifdef ALU_ISSUE_TIMEOUT_EN
                        tmr     <= TMR_LOAD;
`endif
                    end
                end

                S_WAIT_RES: begin
                    if (EX_VLD) begin
                        RES_DATA <= EX_DATA;
                        RES_ERR  <= 1'b0;
                        RES_VLD  <= {owner, ~owner};
                        state    <= S_RESP;
                    end
`ifdef ALU_ISSUE_TIMEOUT_EN
                    // Terminal count reached after TIMEOUT cycles in WAIT_RES.
                    else if (tmr == '0) begin
                        RES_DATA <= '0;
                        RES_ERR  <= 1'b1;
                        RES_VLD  <= {owner, ~owner};
                        state    <= S_RESP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [1:0]    REQ_VLD;
    logic [1:0]    REQ_RDY;
    logic [7:0]    REQ_OP;
    logic [3:0]    REQ_MOVI;
    logic [2*DW-1:0] REQ_A, REQ_B, REQ_IMM;
    logic          MEM_REQ;
    logic          MEM_VLD;
    logic [DW-1:0] MEM_DATA;
    logic          ALU_VLD;
    logic          ALU_RDY;
    logic [3:0]    ALU_OP;
    logic [1:0]    ALU_MOVI;
    logic [DW-1:0] ALU_A, ALU_B, ALU_MEM, ALU_IMM;
    logic          EX_VLD;
    logic [DW-1:0] EX_DATA;
    logic [1:0]    RES_VLD;
    logic [DW-1:0] RES_DATA;
    logic          RES_ERR;

    int checks = 0;
    int errors = 0;
    int res_pulses = 0;

    alu_issue_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY), .REQ_OP(REQ_OP),
        .REQ_MOVI(REQ_MOVI), .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_IMM(REQ_IMM),
        .MEM_REQ(MEM_REQ), .MEM_VLD(MEM_VLD), .MEM_DATA(MEM_DATA),
        .ALU_VLD(ALU_VLD), .ALU_RDY(ALU_RDY), .ALU_OP(ALU_OP),
        .ALU_MOVI(ALU_MOVI), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_MEM(ALU_MEM), .ALU_IMM(ALU_IMM),
        .EX_VLD(EX_VLD), .EX_DATA(EX_DATA),
        .RES_VLD(RES_VLD), .RES_DATA(RES_DATA), .RES_ERR(RES_ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (RES_VLD != 2'b00) res_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2 time units after the rising edge.
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [1:0] movi,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm);
        REQ_OP[i*4 +: 4]   = op;
        REQ_MOVI[i*2 +: 2] = movi;
        REQ_A[i*DW +: DW]  = a;
        REQ_B[i*DW +: DW]  = b;
        REQ_IMM[i*DW +: DW] = imm;
    endtask

    task automatic wait_rdy(output logic [1:0] got);
        got = 2'b00;
        for (int n = 0; n < 10; n++) begin
            if (REQ_RDY != 2'b00) begin
                got = REQ_RDY;
                break;
            end
            step();
        end
    endtask

    task automatic wait_res(output logic [1:0] got);
        got = 2'b00;
        for (int n = 0; n < 10; n++) begin
            if (RES_VLD != 2'b00) begin
                got = RES_VLD;
                break;
            end
            step();
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ_VLD = 2'b00; MEM_VLD = 1'b0; ALU_RDY = 1'b0; EX_VLD = 1'b0;
        step();
        step();
        RST = 1'b0;
    endtask

    logic [1:0] got;
    logic [1:0] exp_order [3];
    int memcnt;
    int cyc;
    int pulses_before;

    initial begin
        RST = 1'b1;
        REQ_VLD = 2'b00; REQ_OP = '0; REQ_MOVI = '0;
        REQ_A = '0; REQ_B = '0; REQ_IMM = '0;
        MEM_VLD = 1'b0; MEM_DATA = '0; ALU_RDY = 1'b0;
        EX_VLD = 1'b0; EX_DATA = '0;
        step();

        // Reset state; requests must be ignored while RST is high.
        REQ_VLD = 2'b11;
        #1;
        chk("rst_req_rdy", 32'(REQ_RDY), 'h0);
        chk("rst_mem_req", 32'(MEM_REQ), 'h0);
        chk("rst_alu_vld", 32'(ALU_VLD), 'h0);
        chk("rst_res_vld", 32'(RES_VLD), 'h0);
        chk("rst_res_err", 32'(RES_ERR), 'h0);
        chk("rst_res_data", 32'(RES_DATA), 'h0);
        step();
        REQ_VLD = 2'b00;

        // Both requesters held for three ops after reset: grant order 0,1,0.
        do_reset();
        set_req(0, 4'h1, 2'b00, 8'h01, 8'h02, 8'h00);
        set_req(1, 4'h2, 2'b10, 8'h03, 8'h04, 8'h05);
        ALU_RDY = 1'b1; EX_VLD = 1'b1; EX_DATA = 8'h11;
        REQ_VLD = 2'b11;
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            wait_rdy(got);
            chk($sformatf("rr_grant%0d", k), 32'(got), 32'(exp_order[k]));
            step();
            wait_res(got);
            chk($sformatf("rr_res%0d", k), 32'(got), 32'(exp_order[k]));
            step();
        end
        REQ_VLD = 2'b00; EX_VLD = 1'b0;

        // Basic op: req0, MOVI=00, 5+3 -> 8 after three cycles. EX_VLD in
        // ISSUE is outside WAIT_RES and must be ignored.
        do_reset();
        set_req(0, 4'h0, 2'b00, 8'h05, 8'h03, 8'h00);
        REQ_VLD = 2'b01; ALU_RDY = 1'b1;
        #1;
        chk("op_req_rdy", 32'(REQ_RDY), 'h1);
        step();
        REQ_VLD = 2'b00;
        chk("op_alu_vld", 32'(ALU_VLD), 'h1);
        chk("op_alu_a", 32'(ALU_A), 'h05);
        chk("op_alu_b", 32'(ALU_B), 'h03);
        chk("op_alu_mem", 32'(ALU_MEM), 'h00);
        EX_VLD = 1'b1; EX_DATA = 8'hFF;
        step();
        chk("op_alu_vld_drop", 32'(ALU_VLD), 'h0);
        chk("op_no_early_res", 32'(RES_VLD), 'h0);
        EX_DATA = 8'h08;
        step();
        EX_VLD = 1'b0;
        chk("op_res_vld", 32'(RES_VLD), 'h1);
        chk("op_res_data", 32'(RES_DATA), 'h08);
        chk("op_res_err", 32'(RES_ERR), 'h0);
        step();
        chk("op_res_pulse_end", 32'(RES_VLD), 'h0);
        chk("op_res_data_hold", 32'(RES_DATA), 'h08);

        // Memory operand: req1 MOVI=01 while req0 also requests (req1 has
        // priority since req0 was granted last); req0 then withdraws.
        set_req(1, 4'h3, 2'b01, 8'h10, 8'h20, 8'h7E);
        set_req(0, 4'h4, 2'b00, 8'h30, 8'h40, 8'h50);
        REQ_VLD = 2'b11; ALU_RDY = 1'b0;
        #1;
        chk("mem_grant", 32'(REQ_RDY), 'h2);
        step();
        REQ_VLD = 2'b00;
        memcnt = 0;
        for (int k = 1; k <= 4; k++) begin
            if (MEM_REQ) memcnt++;
            if (k == 4) begin
                MEM_VLD = 1'b1; MEM_DATA = 8'hA5;
            end
            step();
        end
        MEM_VLD = 1'b0; MEM_DATA = 8'h00;
        chk("mem_req_cycles", 32'(memcnt), 4);
        chk("mem_req_drop", 32'(MEM_REQ), 'h0);
        chk("mem_alu_vld", 32'(ALU_VLD), 'h1);
        chk("mem_alu_mem", 32'(ALU_MEM), 'hA5);
        chk("mem_alu_movi", 32'(ALU_MOVI), 'h1);
        chk("mem_alu_op", 32'(ALU_OP), 'h3);
        chk("mem_alu_imm", 32'(ALU_IMM), 'h7E);
        step();
        chk("mem_issue_hold_vld", 32'(ALU_VLD), 'h1);
        chk("mem_issue_hold_a", 32'(ALU_A), 'h10);
        ALU_RDY = 1'b1;
        step();
        EX_VLD = 1'b1; EX_DATA = 8'hC3;
        step();
        EX_VLD = 1'b0;
        chk("mem_res_vld", 32'(RES_VLD), 'h2);
        chk("mem_res_data", 32'(RES_DATA), 'hC3);
        step();

        // Reserved MOVI: error response, ALU never issued.
        set_req(0, 4'h5, 2'b11, 8'h66, 8'h77, 8'h88);
        REQ_VLD = 2'b01;
        #1;
        chk("rsv_grant", 32'(REQ_RDY), 'h1);
        step();
        REQ_VLD = 2'b00;
        chk("rsv_res_vld", 32'(RES_VLD), 'h1);
        chk("rsv_res_err", 32'(RES_ERR), 'h1);
        chk("rsv_res_data", 32'(RES_DATA), 'h0);
        chk("rsv_no_alu_vld", 32'(ALU_VLD), 'h0);
        step();
        chk("rsv_no_alu_vld2", 32'(ALU_VLD), 'h0);

        // Reset while in WAIT_RES: outputs clear at once, no RES_VLD pulse.
        set_req(0, 4'h6, 2'b10, 8'h99, 8'h44, 8'h42);
        REQ_VLD = 2'b01; ALU_RDY = 1'b1;
        step();
        REQ_VLD = 2'b00;
        chk("imm_alu_mem_zero", 32'(ALU_MEM), 'h0);
        chk("imm_alu_imm", 32'(ALU_IMM), 'h42);
        chk("imm_alu_movi", 32'(ALU_MOVI), 'h2);
        step();
        pulses_before = res_pulses;
`ifdef ALU_ISSUE_TIMEOUT_EN
        for (int k = 0; k < 5; k++) step();
`else
        // No timer: the controller must keep waiting well beyond TIMEOUT.
        for (int k = 0; k < 40; k++) step();
`endif
        chk("wait_no_res", 32'(res_pulses - pulses_before), 0);
        RST = 1'b1;
        #1;
        chk("arst_alu_a", 32'(ALU_A), 'h0);
        chk("arst_alu_imm", 32'(ALU_IMM), 'h0);
        chk("arst_res_data", 32'(RES_DATA), 'h0);
        chk("arst_res_err", 32'(RES_ERR), 'h0);
        EX_VLD = 1'b1; EX_DATA = 8'hEE;
        step();
        step();
        EX_VLD = 1'b0;
        chk("arst_no_pulse", 32'(res_pulses - pulses_before), 0);
        RST = 1'b0;

        // After reset a fresh request is serviced normally.
        set_req(1, 4'h7, 2'b00, 8'h21, 8'h39, 8'h00);
        REQ_VLD = 2'b10;
        #1;
        chk("post_grant", 32'(REQ_RDY), 'h2);
        step();
        REQ_VLD = 2'b00;
        step();
        EX_VLD = 1'b1; EX_DATA = 8'h5A;
        step();
        EX_VLD = 1'b0;
        chk("post_res_vld", 32'(RES_VLD), 'h2);
        chk("post_res_data", 32'(RES_DATA), 'h5A);
        chk("post_res_err", 32'(RES_ERR), 'h0);
        step();

`ifdef ALU_ISSUE_TIMEOUT_EN
        // Timeout: EX_VLD never arrives, error response 16 cycles after
        // entering WAIT_RES.
        set_req(0, 4'h8, 2'b00, 8'h12, 8'h34, 8'h00);
        REQ_VLD = 2'b01; ALU_RDY = 1'b1;
        step();
        REQ_VLD = 2'b00;
        step();
        cyc = 0;
        while (RES_VLD == 2'b00 && cyc < 40) begin
            step();
            cyc++;
        end
        chk("to_cycles", 32'(cyc), 16);
        chk("to_res_vld", 32'(RES_VLD), 'h1);
        chk("to_res_err", 32'(RES_ERR), 'h1);
        chk("to_res_data", 32'(RES_DATA), 'h0);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
